// File: rtl/mem_stage.sv
// MEM stage of the RV32 pipeline: branch resolution, req/ack data-memory access with
// timeout, and the MEM/WB pipeline register feeding writeback.
//
// state  | meaning
// IDLE   | no access outstanding; non-memory instructions retire in one cycle
// ACCESS | dmem request outstanding, waiting for dmem_ack or timeout
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        WB_reg_write,
  input  logic        WB_mem_to_reg,
  input  logic        M_branch,
  input  logic        M_mem_read,
  input  logic        M_mem_write,
  input  logic        ALU_zero,
  input  logic [31:0] branch_adder_sum,
  input  logic [31:0] ALU_result,
  input  logic [31:0] reg_read_data2,
  input  logic [4:0]  rd,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_rd,
  output logic        bus_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          mem_op;
  logic          launch, finish, timeout_hit, wb_load;

  assign mem_op        = M_mem_read | M_mem_write;
  assign branch_target = branch_adder_sum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    pc_src      = 1'b0;
    launch      = 1'b0;
    finish      = 1'b0;
    timeout_hit = 1'b0;
    wb_load     = 1'b0;
    case (state)
      IDLE: begin
        pc_src = M_branch & ALU_zero;
        if (mem_op) begin
          stall     = 1'b1;
          launch    = 1'b1;
          state_nxt = ACCESS;
        end else begin
          wb_load = 1'b1;
        end
      end
      ACCESS: begin
        // A completing ack wins over a timeout landing in the same cycle.
        if (dmem_ack) begin
          wb_load   = 1'b1;
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          finish      = 1'b1;
          state_nxt   = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Upstream must not see a stall while the pipeline is being reset.
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      bus_error     <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_rd         <= '0;
    end else begin
      if (launch) begin
        dmem_req   <= 1'b1;
        dmem_we    <= M_mem_write;
        dmem_addr  <= ALU_result;
        dmem_wdata <= reg_read_data2;
        cnt        <= '0;
      end else if (finish) begin
        dmem_req <= 1'b0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
      end

      if (timeout_hit) bus_error <= 1'b1;

      if (wb_load) begin
        wb_reg_write  <= WB_reg_write;
        wb_mem_to_reg <= WB_mem_to_reg;
        wb_read_data  <= (state == ACCESS && !dmem_we) ? dmem_rdata : '0;
        wb_alu_result <= ALU_result;
        wb_rd         <= rd;
      end else begin
        wb_reg_write  <= 1'b0;
        wb_mem_to_reg <= 1'b0;
      end
    end
  end

endmodule
